// File: rtl/biriscv_fetch_queue_if.sv
`default_nettype none
//==============================================================================
// Module   : biriscv_fetch_queue_if
// Brief    : Fetch-bundle input, decode-lane output and occupancy signals of
//            the biriscv fetch queue, with master (driver) / slave (queue)
//            modports.
// Revision : 1.0 - initial release
//==============================================================================
interface biriscv_fetch_queue_if #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH_W = 3
);
  logic                   flush_i;
  logic                   fetch_valid_i;
  logic [32*FETCH_W-1:0]  fetch_instr_i;
  logic [31:0]            fetch_pc_i;
  logic [FETCH_W-1:0]     fetch_pred_branch_i;
  logic                   fetch_fault_fetch_i;
  logic                   fetch_fault_page_i;
  logic                   fetch_accept_o;
  logic [ISSUE_W-1:0]     out_valid_o;
  logic [32*ISSUE_W-1:0]  out_instr_o;
  logic [32*ISSUE_W-1:0]  out_pc_o;
  logic [ISSUE_W-1:0]     out_fault_fetch_o;
  logic [ISSUE_W-1:0]     out_fault_page_o;
  logic [ISSUE_W-1:0]     out_accept_i;
  logic [DEPTH_W:0]       level_o;

  modport master (
    output flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i,
           fetch_pred_branch_i, fetch_fault_fetch_i, fetch_fault_page_i,
           out_accept_i,
    input  fetch_accept_o, out_valid_o, out_instr_o, out_pc_o,
           out_fault_fetch_o, out_fault_page_o, level_o
  );

  modport slave (
    input  flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i,
           fetch_pred_branch_i, fetch_fault_fetch_i, fetch_fault_page_i,
           out_accept_i,
    output fetch_accept_o, out_valid_o, out_instr_o, out_pc_o,
           out_fault_fetch_o, out_fault_page_o, level_o
  );
endinterface
`default_nettype wire

// File: rtl/biriscv_fetch_queue.sv
`default_nettype none
//==============================================================================
// Module   : biriscv_fetch_queue
// Brief    : Circular instruction queue between fetch and decode. Filters the
//            slots of each fetch bundle (start PC / predicted-taken), packs the
//            survivors and presents up to ISSUE_W in-order lanes to decode.
//            Optional macro BIRISCV_FETCHQ_BYPASS_EN: when the queue is empty
//            a pushed bundle drives the lanes in the same cycle.
// Revision : 1.0 - initial release
//==============================================================================
module biriscv_fetch_queue #(
  parameter int FETCH_W   = 2,
  parameter int FETCH_W_W = 1,
  parameter int ISSUE_W   = 2,
  parameter int DEPTH     = 8,
  parameter int DEPTH_W   = 3
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  biriscv_fetch_queue_if.slave bus
);

  localparam logic [DEPTH_W:0] C_DEPTH   = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] C_FETCH_W = (DEPTH_W+1)'(FETCH_W);

  // Queue state
  logic [DEPTH_W-1:0] r_head;
  logic [DEPTH_W-1:0] r_tail;
  logic [DEPTH_W:0]   r_level;
  logic [31:0]        r_instr [DEPTH];
  logic [31:0]        r_pc    [DEPTH];
  logic [DEPTH-1:0]   r_ffetch;
  logic [DEPTH-1:0]   r_fpage;

  // Packed (kept) view of the incoming bundle
  logic [FETCH_W_W-1:0] w_st;
  logic [31:0]          w_k_instr [FETCH_W];
  logic [31:0]          w_k_pc    [FETCH_W];
  logic [2:0]           w_n;
  logic                 w_fault;
  logic                 w_taken;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_byp;
  logic [ISSUE_W-1:0]   w_valid;
  logic [2:0]           w_m;
  logic                 w_run;
  logic [2:0]           w_skip;
  logic [2:0]           w_stored;
  logic [2:0]           w_head_adv;

  assign w_fault  = bus.fetch_fault_fetch_i | bus.fetch_fault_page_i;
  // Capacity is judged for a whole bundle against the registered level only
  assign w_accept = !rst_i && !bus.flush_i && (r_level <= (C_DEPTH - C_FETCH_W));
  assign w_push   = bus.fetch_valid_i && w_accept;
  assign bus.fetch_accept_o = w_accept;
  assign bus.level_o        = r_level;

  // Slot filtering: survivors are the contiguous run starting at the start
  // slot and ending at (and including) the first predicted-taken slot.
  always_comb begin
    w_st    = '0;
    w_n     = '0;
    w_taken = 1'b0;
    if (FETCH_W > 1)
      w_st = bus.fetch_pc_i[2+FETCH_W_W-1:2];
    for (int s = 0; s < FETCH_W; s++) begin
      if (!w_taken && (s >= int'(w_st))) begin
        w_n = w_n + 3'd1;
        if (bus.fetch_pred_branch_i[s])
          w_taken = 1'b1;
      end
    end
    for (int j = 0; j < FETCH_W; j++) begin
      int si;
      si = int'(w_st) + j;
      w_k_instr[j] = '0;
      w_k_pc[j]    = '0;
      if (si < FETCH_W) begin
        w_k_instr[j] = bus.fetch_instr_i[32*si +: 32];
        if (FETCH_W == 1)
          w_k_pc[j] = {bus.fetch_pc_i[31:2], 2'b00};
        else
          w_k_pc[j] = {bus.fetch_pc_i[31:2+FETCH_W_W], si[FETCH_W_W-1:0], 2'b00};
      end
    end
    // A faulting bundle collapses to a single entry carrying the raw PC
    if (w_fault) begin
      w_n          = 3'd1;
      w_k_instr[0] = bus.fetch_instr_i[31:0];
      w_k_pc[0]    = bus.fetch_pc_i;
    end
  end

`ifdef BIRISCV_FETCHQ_BYPASS_EN
  assign w_byp = w_push && (r_level == '0);
`else
  assign w_byp = 1'b0;
`endif

  // Lane outputs: registered entries head+k, or the bundle itself when bypassing
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      logic [DEPTH_W-1:0] idx;
      idx = r_head + DEPTH_W'(k);
      w_valid[k]                 = (r_level > (DEPTH_W+1)'(k));
      bus.out_instr_o[32*k +: 32] = r_instr[idx];
      bus.out_pc_o[32*k +: 32]    = r_pc[idx];
      bus.out_fault_fetch_o[k]    = r_ffetch[idx];
      bus.out_fault_page_o[k]     = r_fpage[idx];
      if (w_byp) begin
        w_valid[k] = (k < int'(w_n));
        if (k < FETCH_W) begin
          bus.out_instr_o[32*k +: 32] = w_k_instr[k];
          bus.out_pc_o[32*k +: 32]    = w_k_pc[k];
          bus.out_fault_fetch_o[k]    = bus.fetch_fault_fetch_i;
          bus.out_fault_page_o[k]     = bus.fetch_fault_page_i;
        end
      end
    end
    bus.out_valid_o = w_valid;
  end

  // Pop count: leading run of valid&accept from lane 0, plus push bookkeeping
  always_comb begin
    w_m   = '0;
    w_run = 1'b1;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (w_run && w_valid[k] && bus.out_accept_i[k])
        w_m = w_m + 3'd1;
      else
        w_run = 1'b0;
    end
    w_skip     = w_byp ? w_m : 3'd0;
    w_stored   = w_push ? (w_n - w_skip) : 3'd0;
    w_head_adv = w_byp ? 3'd0 : w_m;
  end

  // Pointer and occupancy registers; flush and reset both empty the queue
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      r_head  <= r_head + DEPTH_W'(w_head_adv);
      r_tail  <= r_tail + DEPTH_W'(w_stored);
      r_level <= r_level + (DEPTH_W+1)'(w_push ? w_n : 3'd0) - (DEPTH_W+1)'(w_m);
    end
  end

  // Entry storage: kept slots (minus any bypass-consumed ones) written from tail
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (w_push && (j >= int'(w_skip)) && (j < int'(w_n))) begin
        r_instr[r_tail + DEPTH_W'(j - int'(w_skip))]  <= w_k_instr[j];
        r_pc[r_tail + DEPTH_W'(j - int'(w_skip))]     <= w_k_pc[j];
        r_ffetch[r_tail + DEPTH_W'(j - int'(w_skip))] <= bus.fetch_fault_fetch_i;
        r_fpage[r_tail + DEPTH_W'(j - int'(w_skip))]  <= bus.fetch_fault_page_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biriscv_fetch_queue.sv
`default_nettype none
//==============================================================================
// Module   : tb_biriscv_fetch_queue
// Brief    : Directed self-checking bench for biriscv_fetch_queue
//            (FETCH_W=2, ISSUE_W=2, DEPTH=8).
// Revision : 1.0 - initial release
//==============================================================================
module tb_biriscv_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  biriscv_fetch_queue_if #(.FETCH_W(2), .ISSUE_W(2), .DEPTH_W(3)) bus ();

  biriscv_fetch_queue #(
    .FETCH_W(2), .FETCH_W_W(1), .ISSUE_W(2), .DEPTH(8), .DEPTH_W(3)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i0,
                        input logic [1:0] pred);
    bus.fetch_valid_i       = 1'b1;
    bus.fetch_pc_i          = pc;
    bus.fetch_instr_i       = {i1, i0};
    bus.fetch_pred_branch_i = pred;
  endtask

  initial begin
    bus.flush_i             = 1'b0;
    bus.fetch_fault_fetch_i = 1'b0;
    bus.fetch_fault_page_i  = 1'b0;
    bus.out_accept_i        = 2'b00;
    bundle(32'h8000_0000, 32'h11, 32'h22, 2'b00);

    // Reset held two cycles with a valid bundle present
    tick();
    chk("rst_accept_1", 64'(bus.fetch_accept_o), 64'd0);
    chk("rst_valid_1",  64'(bus.out_valid_o),    64'd0);
    chk("rst_level_1",  64'(bus.level_o),        64'd0);
    tick();
    chk("rst_accept_2", 64'(bus.fetch_accept_o), 64'd0);
    chk("rst_level_2",  64'(bus.level_o),        64'd0);
    rst = 1'b0;
    bus.fetch_valid_i = 1'b0;
    #1;
    chk("post_rst_accept", 64'(bus.fetch_accept_o), 64'd1);
    chk("post_rst_valid",  64'(bus.out_valid_o),    64'd0);

    // Aligned bundle
    bundle(32'h8000_0000, 32'h0010_0093, 32'h0000_0013, 2'b00);
    tick();
    bus.fetch_valid_i = 1'b0;
    chk("al_valid",  64'(bus.out_valid_o),        64'h3);
    chk("al_pc0",    64'(bus.out_pc_o[31:0]),     64'h8000_0000);
    chk("al_pc1",    64'(bus.out_pc_o[63:32]),    64'h8000_0004);
    chk("al_instr1", 64'(bus.out_instr_o[63:32]), 64'h0010_0093);
    chk("al_level",  64'(bus.level_o),            64'd2);
    bus.out_accept_i = 2'b11;
    tick();
    bus.out_accept_i = 2'b00;
    chk("al_pop_level", 64'(bus.level_o),     64'd0);
    chk("al_pop_valid", 64'(bus.out_valid_o), 64'd0);

    // Start slot 1: slot 0 dropped
    bundle(32'h8000_0004, 32'hAAAA_0001, 32'hBBBB_0000, 2'b00);
    tick();
    bus.fetch_valid_i = 1'b0;
    chk("st_level",  64'(bus.level_o),           64'd1);
    chk("st_valid",  64'(bus.out_valid_o),       64'h1);
    chk("st_pc0",    64'(bus.out_pc_o[31:0]),    64'h8000_0004);
    chk("st_instr0", 64'(bus.out_instr_o[31:0]), 64'hAAAA_0001);
    bus.out_accept_i = 2'b01;
    tick();
    bus.out_accept_i = 2'b00;
    chk("st_pop_level", 64'(bus.level_o), 64'd0);

    // Slot 0 predicted taken: slot 1 dropped
    bundle(32'h0000_1000, 32'hCCCC_0001, 32'hCCCC_0000, 2'b01);
    tick();
    bus.fetch_valid_i = 1'b0;
    chk("pb_level",  64'(bus.level_o),           64'd1);
    chk("pb_pc0",    64'(bus.out_pc_o[31:0]),    64'h0000_1000);
    chk("pb_instr0", 64'(bus.out_instr_o[31:0]), 64'hCCCC_0000);
    bus.out_accept_i = 2'b01;
    tick();
    bus.out_accept_i = 2'b00;
    chk("pb_pop_level", 64'(bus.level_o), 64'd0);

    // Fill to full (wraps around index 7 -> 0)
    for (int i = 0; i < 4; i++) begin
      bundle(32'h4000 + 32'(8*i), 32'h4000_0000 + 32'(2*i+1), 32'h4000_0000 + 32'(2*i), 2'b00);
      tick();
      if (i == 2) begin
        chk("fill3_level",  64'(bus.level_o),        64'd6);
        chk("fill3_accept", 64'(bus.fetch_accept_o), 64'd1);
      end
    end
    bus.fetch_valid_i = 1'b0;
    #1;
    chk("full_level",  64'(bus.level_o),        64'd8);
    chk("full_accept", 64'(bus.fetch_accept_o), 64'd0);
    chk("full_pc0",    64'(bus.out_pc_o[31:0]),  64'h4000);
    chk("full_pc1",    64'(bus.out_pc_o[63:32]), 64'h4004);

    // Partial pops
    bus.out_accept_i = 2'b10;
    tick();
    chk("pop10_level", 64'(bus.level_o), 64'd8);
    bus.out_accept_i = 2'b01;
    tick();
    chk("pop01_level",  64'(bus.level_o),         64'd7);
    chk("pop01_accept", 64'(bus.fetch_accept_o),  64'd0);
    chk("pop01_pc0",    64'(bus.out_pc_o[31:0]),  64'h4004);
    bus.out_accept_i = 2'b11;
    tick();
    bus.out_accept_i = 2'b00;
    chk("pop11_level",  64'(bus.level_o),           64'd5);
    chk("pop11_accept", 64'(bus.fetch_accept_o),    64'd1);
    chk("pop11_pc0",    64'(bus.out_pc_o[31:0]),    64'h400C);
    chk("pop11_instr0", 64'(bus.out_instr_o[31:0]), 64'h4000_0003);

    // Flush with simultaneous push and pop
    bus.flush_i = 1'b1;
    bundle(32'h5000, 32'h5000_0001, 32'h5000_0000, 2'b00);
    bus.out_accept_i = 2'b11;
    #1;
    chk("fl_accept", 64'(bus.fetch_accept_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.out_accept_i = 2'b00;
    #1;
    chk("fl_level", 64'(bus.level_o),     64'd0);
    chk("fl_valid", 64'(bus.out_valid_o), 64'd0);
    bundle(32'h3000, 32'h3000_0001, 32'h3000_0000, 2'b00);
    tick();
    bus.fetch_valid_i = 1'b0;
    chk("afl_pc0",    64'(bus.out_pc_o[31:0]),    64'h3000);
    chk("afl_instr0", 64'(bus.out_instr_o[31:0]), 64'h3000_0000);
    chk("afl_level",  64'(bus.level_o),           64'd2);
    bus.out_accept_i = 2'b11;
    tick();
    bus.out_accept_i = 2'b00;
    chk("afl_pop_level", 64'(bus.level_o), 64'd0);

    // Page-fault bundle: single entry, slot 0 instruction
    bundle(32'h2000, 32'h2F00_0013, 32'h2000_0013, 2'b00);
    bus.fetch_fault_page_i = 1'b1;
    tick();
    bus.fetch_valid_i = 1'b0;
    bus.fetch_fault_page_i = 1'b0;
    chk("pf_level",  64'(bus.level_o),            64'd1);
    chk("pf_page0",  64'(bus.out_fault_page_o[0]),  64'd1);
    chk("pf_fetch0", 64'(bus.out_fault_fetch_o[0]), 64'd0);
    chk("pf_instr0", 64'(bus.out_instr_o[31:0]),  64'h2000_0013);
    chk("pf_pc0",    64'(bus.out_pc_o[31:0]),     64'h2000);

    // Fetch-fault bundle at odd slot PC: still slot 0 instruction, raw PC
    bundle(32'h2004, 32'h2F00_0093, 32'h2100_0013, 2'b00);
    bus.fetch_fault_fetch_i = 1'b1;
    tick();
    bus.fetch_valid_i = 1'b0;
    bus.fetch_fault_fetch_i = 1'b0;
    chk("ff_level",  64'(bus.level_o),              64'd2);
    chk("ff_pc1",    64'(bus.out_pc_o[63:32]),      64'h2004);
    chk("ff_instr1", 64'(bus.out_instr_o[63:32]),   64'h2100_0013);
    chk("ff_fetch1", 64'(bus.out_fault_fetch_o[1]), 64'd1);
    chk("ff_page1",  64'(bus.out_fault_page_o[1]),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/biriscv_fetch_queue.md
# biriscv_fetch_queue

Parametrised instruction queue between the fetch unit and the decoder. It accepts a fetch bundle of `FETCH_W` 32-bit slots per cycle, drops slots before the fetch PC and after a predicted-taken slot, and packs the surviving instructions into a circular buffer. It presents up to `ISSUE_W` in-order instructions per cycle to decode, each with its own handshake. It generalises the current fixed 64-bit fetch / dual-issue path to arbitrary fetch width, issue width and depth, and adds an occupancy output and a flush.

## Interface
- `FETCH_W`, default 2: slots per fetch bundle; power of two, 1..4.
- `FETCH_W_W`, default 1: log2(`FETCH_W`); minimum 1.
- `ISSUE_W`, default 2: output lanes; 1..4.
- `DEPTH`, default 8: queue entries, one instruction each; power of two, at least `FETCH_W`+`ISSUE_W`.
- `DEPTH_W`, default 3: log2(`DEPTH`).

Ports:
- `clk_i`  in  1  clock; the block has one clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discard all queued instructions (driven by the branch request).
- `fetch_valid_i`  in  1  bundle valid.
- `fetch_instr_i`  in  32*`FETCH_W`  slot s in bits [32s+31:32s].
- `fetch_pc_i`  in  32  PC of the first valid instruction in the bundle.
- `fetch_pred_branch_i`  in  `FETCH_W`  slot predicted taken.
- `fetch_fault_fetch_i`  in  1  bus error on this bundle.
- `fetch_fault_page_i`  in  1  page fault on this bundle.
- `fetch_accept_o`  out  1  bundle accepted.
- `out_valid_o`  out  `ISSUE_W`  lane valid.
- `out_instr_o`  out  32*`ISSUE_W`  lane instruction.
- `out_pc_o`  out  32*`ISSUE_W`  lane PC.
- `out_fault_fetch_o`  out  `ISSUE_W`  lane carries a fetch fault.
- `out_fault_page_o`  out  `ISSUE_W`  lane carries a page fault.
- `out_accept_i`  in  `ISSUE_W`  lane consumed.
- `level_o`  out  `DEPTH_W`+1  registered occupancy.

## Operation
- State:
  - head and tail pointers, `DEPTH_W` bits each, wrapping modulo `DEPTH`.
  - registered `level`, 0..`DEPTH`.
  - per entry: instruction, PC and the two fault bits.
- Start slot: `st = fetch_pc_i[2+FETCH_W_W-1:2]`. Slot s is kept when both hold:
  - `s >= st`;
  - no slot p with `st <= p < s` has `fetch_pred_branch_i[p]` set.
- Kept PC: the PC of kept slot s is `{fetch_pc_i[31:2+FETCH_W_W], s[FETCH_W_W-1:0], 2'b00}`.
- Faulting bundle: if either fault bit is set, only one entry is written. It holds instr 0, PC `fetch_pc_i` and the fault bits.
- Accept: `fetch_accept_o = !rst_i && !flush_i && (DEPTH - level >= FETCH_W)`.
  - Capacity is always evaluated for a full bundle, using the current `level`.
  - Pops in the same cycle do not free space for that cycle's push.
- Push: when `fetch_valid_i && fetch_accept_o`, the n kept slots are written in slot order at tail..tail+n-1, and tail advances by n.
- Output: lane k shows entry head+k, with `out_valid_o[k] = (level > k)`.
- Pop:
  - popped count m = the number of leading ones of `out_valid_o & out_accept_i`, counting from lane 0.
  - Accept bits after the first zero are ignored; for example 2'b10 pops nothing.
  - head advances by m.
- Level update: `level <= level + n - m`.
- Flush: on `flush_i`, head, tail and `level` become 0 at the next edge. A same-cycle push is discarded, and same-cycle pops are irrelevant.
- Reset (`rst_i`): clears head, tail and `level`. While `rst_i` is high and on the cycle after it:
  - all `out_valid_o` = 0;
  - `level_o` = 0;
  - `fetch_accept_o` = 0 while `rst_i` is high.
  - Data outputs are don't-care whenever their lane is invalid.

## Timing
- Push-to-output latency is 1 cycle with no bypass: an entry written at edge t is visible on lane outputs after t.
- `fetch_accept_o` is combinational from `level`, `rst_i` and `flush_i` only. It does not depend on `fetch_valid_i` or `out_accept_i`.
- `out_valid_o` and the lane data are pure functions of registered state. `out_accept_i` affects only the next state.
- Throughput: `FETCH_W` instructions in and `ISSUE_W` instructions out per cycle, sustained while `level` stays within bounds.
- Full condition: `level > DEPTH - FETCH_W`, giving `fetch_accept_o` = 0. Empty condition: `level` = 0, giving all lanes invalid.
- Wrap-around: the pointer arithmetic wraps silently. Entry writes across the index `DEPTH-1`→0 boundary are contiguous in modulo order.

## Configuration
- Macro `BIRISCV_FETCHQ_BYPASS_EN`, defined:
  - When `level` = 0 and a bundle is pushed, the kept slots drive the lanes combinationally in the same cycle.
  - Bypassed lanes that are popped are not written; only the remainder is stored.
  - Faulting bundles bypass too.
  - Flush still suppresses the bypass.
- Not defined: strict 1-cycle latency as described above.

## Test plan
- Reset:
  - Stimulus: `rst_i` = 1 for 2 cycles with `fetch_valid_i` = 1.
  - Required: `fetch_accept_o` = 0, `out_valid_o` = 0, `level_o` = 0.
  - Required after release: `fetch_accept_o` = 1.
- Aligned bundle (FETCH_W=2, ISSUE_W=2, DEPTH=8):
  - Stimulus: push pc 0x80000000, instrs 0x00000013 and 0x00100093, no prediction.
  - Required next cycle: `out_valid_o` = 2'b11, PCs 0x80000000 and 0x80000004.
  - Stimulus: `out_accept_i` = 2'b11. Required: `level_o` = 0.
- Slot filtering:
  - Stimulus: push pc 0x80000004. Required: 1 entry, lane0 PC 0x80000004.
  - Stimulus: push pc 0x1000 with `fetch_pred_branch_i` = 2'b01. Required: 1 entry, lane0 PC 0x1000.
- Full and partial pop:
  - Stimulus: 4 pushes with no pops. Required: `level_o` = 6 with `fetch_accept_o` = 1 after three pushes; `level_o` = 8 with `fetch_accept_o` = 0 after four.
  - Stimulus: `out_accept_i` = 2'b10. Required: `level_o` stays 8.
  - Stimulus: `out_accept_i` = 2'b01. Required: `level_o` = 7, `fetch_accept_o` = 0.
  - Stimulus: then `out_accept_i` = 2'b11. Required: `level_o` = 5, `fetch_accept_o` = 1.
- Fault: push with `fetch_fault_page_i` = 1 at pc 0x2000 → 1 entry, lane0 `out_fault_page_o` = 1, instr 0.
- Flush: `flush_i` with a simultaneous push and accept at `level_o` = 5 → next cycle `level_o` = 0 and `out_valid_o` = 0; subsequent push at 0x3000 appears as the first output.
